// File: rtl/jtlabrun_scan2x.sv
// jtlabrun_scan2x: 15 kHz to 31 kHz line doubler with a ping-pong line buffer.
// Optional macro JTLABRUN_SCANLINES_EN dims the repeat pass to 75 %.
module jtlabrun_scan2x #(
   parameter int AW       = 9,
   parameter int HLEN_RST = 384,
   parameter int HSW      = 28
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pxl_cen,
   input  logic       pxl2_cen,
   input  logic       LHBL,
   input  logic       LVBL,
   input  logic       HS,
   input  logic       VS,
   input  logic [4:0] red,
   input  logic [4:0] green,
   input  logic [4:0] blue,
   output logic [4:0] dbl_red,
   output logic [4:0] dbl_green,
   output logic [4:0] dbl_blue,
   output logic       dbl_LHBL,
   output logic       dbl_LVBL,
   output logic       dbl_HS,
   output logic       dbl_VS
);

   localparam int LW    = AW + 1;
   localparam int DEPTH = 2 ** (AW + 1);
   localparam int CW    = $clog2(HSW + 1);

   localparam logic [AW-1:0] WMAX    = '1;
   localparam logic [LW-1:0] LEN_RST = LW'(HLEN_RST);
   localparam logic [LW-1:0] LEN_MIN = LW'(16);
   localparam logic [CW-1:0] HSW_C   = CW'(HSW);

   // line buffer, one bank per input line, {LHBL,r,g,b}
   logic [15:0]   mem [DEPTH];
   logic [15:0]   mem_q;
   logic          we;
   logic [AW:0]   waddr;
   logic [AW:0]   raddr;

   logic          hs_q,       hs_d;
   logic [AW-1:0] wr_addr_q,  wr_addr_d;
   logic          bank_q,     bank_d;
   logic [LW-1:0] line_len_q, line_len_d;
   logic [AW-1:0] rd_addr_q,  rd_addr_d;
   logic          rep_q,      rep_d;
   logic [CW-1:0] hcnt_q,     hcnt_d;
   logic          lvbl_lat_q, lvbl_lat_d;
   logic          vs_lat_q,   vs_lat_d;
   logic          lvbl_cur_q, lvbl_cur_d;
   logic          vs_cur_q,   vs_cur_d;

   logic          hsp_q,      hsp_d;
   logic          lvblp_q,    lvblp_d;
   logic          vsp_q,      vsp_d;
`ifdef JTLABRUN_SCANLINES_EN
   logic          repp_q,     repp_d;
`endif

   logic [4:0]    red_q,   red_d;
   logic [4:0]    green_q, green_d;
   logic [4:0]    blue_q,  blue_d;
   logic          lhbl_q,  lhbl_d;
   logic          lvbl_q,  lvbl_d;
   logic          hso_q,   hso_d;
   logic          vso_q,   vso_d;

   logic          hs_edge;
   logic [LW-1:0] wr_next;
   logic          rd_wrap;

   assign hs_edge = pxl_cen & HS & ~hs_q;
   assign wr_next = {1'b0, wr_addr_q} + LW'(1);
   assign rd_wrap = {1'b0, rd_addr_q} >= (line_len_q - LW'(1));

   // write/read sequencing: HS edge restarts both sides, else normal advance
   always_comb begin
      hs_d       = hs_q;
      wr_addr_d  = wr_addr_q;
      bank_d     = bank_q;
      line_len_d = line_len_q;
      rd_addr_d  = rd_addr_q;
      rep_d      = rep_q;
      hcnt_d     = hcnt_q;
      lvbl_lat_d = lvbl_lat_q;
      vs_lat_d   = vs_lat_q;
      lvbl_cur_d = lvbl_cur_q;
      vs_cur_d   = vs_cur_q;
      if (pxl_cen) hs_d = HS;
      if (hs_edge) begin
         wr_addr_d  = '0;
         if (wr_next >= LEN_MIN) line_len_d = wr_next;
         bank_d     = ~bank_q;
         rd_addr_d  = '0;
         rep_d      = 1'b0;
         hcnt_d     = '0;
         lvbl_lat_d = LVBL;
         vs_lat_d   = VS;
         lvbl_cur_d = lvbl_lat_q;
         vs_cur_d   = vs_lat_q;
      end else begin
         if (pxl_cen && wr_addr_q != WMAX) begin
            wr_addr_d = wr_addr_q + AW'(1);
         end
         if (pxl2_cen) begin
            if (rd_wrap) begin
               rd_addr_d = '0;
               rep_d     = ~rep_q;
               hcnt_d    = '0;
               if (rep_q) begin
                  lvbl_cur_d = lvbl_lat_q;
                  vs_cur_d   = vs_lat_q;
               end
            end else begin
               rd_addr_d = rd_addr_q + AW'(1);
               if (hcnt_q != HSW_C) hcnt_d = hcnt_q + CW'(1);
            end
         end
      end
   end

   // saturated write address drops extra pixels instead of overwriting
   assign we    = pxl_cen & (hs_edge | (wr_addr_q != WMAX));
   assign waddr = {bank_d, wr_addr_d};
   assign raddr = {~bank_q, rd_addr_q};

   // buffer storage and registered read of the opposite bank
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= {LHBL, red, green, blue};
      mem_q <= mem[raddr];
   end

   // side-band bits delayed to line up with the buffer read data
   always_comb begin
      hsp_d   = hcnt_q < HSW_C;
      lvblp_d = lvbl_cur_q;
      vsp_d   = vs_cur_q;
`ifdef JTLABRUN_SCANLINES_EN
      repp_d  = rep_q;
`endif
   end

   // final colour gating by the stored blank bit
   always_comb begin
      logic [4:0] r_s, g_s, b_s;
      r_s = mem_q[14:10];
      g_s = mem_q[9:5];
      b_s = mem_q[4:0];
`ifdef JTLABRUN_SCANLINES_EN
      if (repp_q) begin
         r_s = r_s - (r_s >> 2);
         g_s = g_s - (g_s >> 2);
         b_s = b_s - (b_s >> 2);
      end
`endif
      red_d   = mem_q[15] ? r_s : 5'd0;
      green_d = mem_q[15] ? g_s : 5'd0;
      blue_d  = mem_q[15] ? b_s : 5'd0;
      lhbl_d  = mem_q[15];
      lvbl_d  = lvblp_q;
      hso_d   = hsp_q;
      vso_d   = vsp_q;
   end

   // control state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hs_q       <= 1'b0;
         wr_addr_q  <= '0;
         bank_q     <= 1'b0;
         line_len_q <= LEN_RST;
         rd_addr_q  <= '0;
         rep_q      <= 1'b0;
         hcnt_q     <= HSW_C;
         lvbl_lat_q <= 1'b0;
         vs_lat_q   <= 1'b0;
         lvbl_cur_q <= 1'b0;
         vs_cur_q   <= 1'b0;
      end else begin
         hs_q       <= hs_d;
         wr_addr_q  <= wr_addr_d;
         bank_q     <= bank_d;
         line_len_q <= line_len_d;
         rd_addr_q  <= rd_addr_d;
         rep_q      <= rep_d;
         hcnt_q     <= hcnt_d;
         lvbl_lat_q <= lvbl_lat_d;
         vs_lat_q   <= vs_lat_d;
         lvbl_cur_q <= lvbl_cur_d;
         vs_cur_q   <= vs_cur_d;
      end
   end

   // alignment and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hsp_q   <= 1'b0;
         lvblp_q <= 1'b0;
         vsp_q   <= 1'b0;
`ifdef JTLABRUN_SCANLINES_EN
         repp_q  <= 1'b0;
`endif
         red_q   <= '0;
         green_q <= '0;
         blue_q  <= '0;
         lhbl_q  <= 1'b0;
         lvbl_q  <= 1'b0;
         hso_q   <= 1'b0;
         vso_q   <= 1'b0;
      end else begin
         hsp_q   <= hsp_d;
         lvblp_q <= lvblp_d;
         vsp_q   <= vsp_d;
`ifdef JTLABRUN_SCANLINES_EN
         repp_q  <= repp_d;
`endif
         red_q   <= red_d;
         green_q <= green_d;
         blue_q  <= blue_d;
         lhbl_q  <= lhbl_d;
         lvbl_q  <= lvbl_d;
         hso_q   <= hso_d;
         vso_q   <= vso_d;
      end
   end

   assign dbl_red   = red_q;
   assign dbl_green = green_q;
   assign dbl_blue  = blue_q;
   assign dbl_LHBL  = lhbl_q;
   assign dbl_LVBL  = lvbl_q;
   assign dbl_HS    = hso_q;
   assign dbl_VS    = vso_q;

endmodule
